pio_sm_sequencer: RTL and testbench

Per-state-machine execution sequencer for the PIO block. It watches the instruction fetched at the current PC and generates the `pc_en`, `jump_en` and `jump` controls for the program counter. It also owns instruction delay cycles, execution stalls, the pause and restart controls, and JMP condition evaluation. It sits between instruction memory and `program_counter`, with one instance per state machine.

---
 rtl/pio_sm_sequencer_if.sv | 36 +++
 rtl/pio_sm_sequencer.sv | 136 +++++++++++++
 tb/tb_pio_sm_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pio_sm_sequencer_if.sv
// Control bundle between a PIO state machine's instruction path and its sequencer.
// The master drives instruction and condition inputs; the slave returns PC and strobe controls.
interface pio_sm_sequencer_if;
    localparam int unsigned InstrW = 16;
    localparam int unsigned AddrW  = 5;

    logic              sm_en;
    logic              restart;
    logic [InstrW-1:0] instr;
    logic              exec_stall;
    logic              x_zero;
    logic              y_zero;
    logic              x_ne_y;
    logic              pin;
    logic              osr_empty;

    logic              pc_en;
    logic              jump_en;
    logic [AddrW-1:0]  jump;
    logic              x_dec;
    logic              y_dec;
    logic              exec_valid;
    logic              delay_busy;

    modport master (
        output sm_en, restart, instr, exec_stall,
        output x_zero, y_zero, x_ne_y, pin, osr_empty,
        input  pc_en, jump_en, jump, x_dec, y_dec, exec_valid, delay_busy
    );

    modport slave (
        input  sm_en, restart, instr, exec_stall,
        input  x_zero, y_zero, x_ne_y, pin, osr_empty,
        output pc_en, jump_en, jump, x_dec, y_dec, exec_valid, delay_busy
    );
endinterface

// File: rtl/pio_sm_sequencer.sv
// Per-state-machine execution sequencer: turns the instruction at the current PC into
// PC advance/jump controls, handling delay cycles, stalls, pause, restart and JMP conditions.
module pio_sm_sequencer (
    input  logic                 clk,
    input  logic                 rst_n,
    pio_sm_sequencer_if.slave    bus_if
);
    localparam int unsigned AddrW  = 5;
    localparam int unsigned DelayW = 5;
    localparam int unsigned OpW    = 3;
    localparam int unsigned CondW  = 3;

    localparam logic [OpW-1:0]   OpJmp      = 3'b000;
    localparam logic [CondW-1:0] CondAlways = 3'd0;
    localparam logic [CondW-1:0] CondXZero  = 3'd1;
    localparam logic [CondW-1:0] CondXDec   = 3'd2;
    localparam logic [CondW-1:0] CondYZero  = 3'd3;
    localparam logic [CondW-1:0] CondYDec   = 3'd4;
    localparam logic [CondW-1:0] CondXNeY   = 3'd5;
    localparam logic [CondW-1:0] CondPin    = 3'd6;
    localparam logic [CondW-1:0] CondOsr    = 3'd7;

    typedef enum logic {
        ST_EXEC  = 1'b0,
        ST_DELAY = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [DelayW-1:0]  dcnt_q,  dcnt_d;

    logic [OpW-1:0]     opcode;
    logic [DelayW-1:0]  delay;
    logic [CondW-1:0]   cond;
    logic [AddrW-1:0]   target;
    logic               cond_true;

    logic               pc_en_c;
    logic               jump_en_c;
    logic [AddrW-1:0]   jump_c;
    logic               x_dec_c;
    logic               y_dec_c;
    logic               exec_valid_c;
    logic               delay_busy_c;

    assign opcode = bus_if.instr[15:13];
    assign delay  = bus_if.instr[12:8];
    assign cond   = bus_if.instr[7:5];
    assign target = bus_if.instr[4:0];

    // JMP condition on the scratch values before any decrement this cycle.
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            CondAlways: cond_true = 1'b1;
            CondXZero:  cond_true = bus_if.x_zero;
            CondXDec:   cond_true = !bus_if.x_zero;
            CondYZero:  cond_true = bus_if.y_zero;
            CondYDec:   cond_true = !bus_if.y_zero;
            CondXNeY:   cond_true = bus_if.x_ne_y;
            CondPin:    cond_true = bus_if.pin;
            CondOsr:    cond_true = !bus_if.osr_empty;
            default:    cond_true = 1'b0;
        endcase
    end

    // Next state and outputs; restart outranks pause, which outranks normal sequencing.
    always_comb begin
        state_d      = state_q;
        dcnt_d       = dcnt_q;
        pc_en_c      = 1'b0;
        jump_en_c    = 1'b0;
        jump_c       = '0;
        x_dec_c      = 1'b0;
        y_dec_c      = 1'b0;
        exec_valid_c = 1'b0;
        delay_busy_c = 1'b0;

        if (!rst_n) begin
            state_d = ST_EXEC;
            dcnt_d  = '0;
        end else if (bus_if.restart) begin
            state_d = ST_EXEC;
            dcnt_d  = '0;
        end else if (bus_if.sm_en) begin
            jump_c = target;
            case (state_q)
                ST_EXEC: begin
                    exec_valid_c = 1'b1;
                    if (!bus_if.exec_stall) begin
                        pc_en_c = 1'b1;
                        if (opcode == OpJmp) begin
                            jump_en_c = cond_true;
                            x_dec_c   = (cond == CondXDec);
                            y_dec_c   = (cond == CondYDec);
                        end
                        if (delay != '0) begin
                            dcnt_d  = delay;
                            state_d = ST_DELAY;
                        end
                    end
                end
                ST_DELAY: begin
                    delay_busy_c = 1'b1;
                    if (dcnt_q <= DelayW'(1)) begin
                        dcnt_d  = '0;
                        state_d = ST_EXEC;
                    end else begin
                        dcnt_d  = DelayW'(dcnt_q - DelayW'(1));
                    end
                end
                default: begin
                    state_d = ST_EXEC;
                    dcnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EXEC;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign bus_if.pc_en      = pc_en_c;
    assign bus_if.jump_en    = jump_en_c;
    assign bus_if.jump       = jump_c;
    assign bus_if.x_dec      = x_dec_c;
    assign bus_if.y_dec      = y_dec_c;
    assign bus_if.exec_valid = exec_valid_c;
    assign bus_if.delay_busy = delay_busy_c;
endmodule

// File: tb/tb_pio_sm_sequencer.sv
// Scoreboard bench for pio_sm_sequencer: directed scenarios then random traffic, each cycle's
// expected outputs come from a remaining-delay-cycles model and are checked by a separate monitor.
module tb_pio_sm_sequencer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pio_sm_sequencer_if sif ();

    pio_sm_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (sif.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_en;
        logic       jump_en;
        logic [4:0] jump;
        logic       x_dec;
        logic       y_dec;
        logic       exec_valid;
        logic       delay_busy;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   cycle  = 0;
    int   rem    = 0;
    bit   mon_on = 1'b0;

    localparam logic [2:0] NOP = 3'b101;
    localparam logic [2:0] JMP = 3'b000;

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [4:0] dly,
                                       input logic [2:0] cnd, input logic [4:0] tgt);
        return {op, dly, cnd, tgt};
    endfunction

    // One enabled/disabled clock cycle: drive inputs, predict outputs, advance the model.
    // c = {x_zero, y_zero, x_ne_y, pin, osr_empty}
    task automatic step(input logic rstn, input logic en, input logic rs,
                        input logic [15:0] ins, input logic st, input logic [4:0] c);
        obs_t       e;
        logic [7:0] truth;
        logic [2:0] cc;
        @(posedge clk);
        #1;
        rst_n          = rstn;
        sif.sm_en      = en;
        sif.restart    = rs;
        sif.instr      = ins;
        sif.exec_stall = st;
        sif.x_zero     = c[4];
        sif.y_zero     = c[3];
        sif.x_ne_y     = c[2];
        sif.pin        = c[1];
        sif.osr_empty  = c[0];

        e     = '0;
        cc    = ins[7:5];
        truth = {!c[0], c[1], c[2], !c[3], c[3], !c[4], c[4], 1'b1};
        if (!rstn || rs) begin
            rem = 0;
        end else if (en) begin
            e.jump = ins[4:0];
            if (rem > 0) begin
                e.delay_busy = 1'b1;
                rem = rem - 1;
            end else begin
                e.exec_valid = 1'b1;
                if (!st) begin
                    e.pc_en = 1'b1;
                    if (ins[15:13] == JMP) begin
                        e.jump_en = truth[cc];
                        e.x_dec   = (cc == 3'd2);
                        e.y_dec   = (cc == 3'd4);
                    end
                    rem = int'(ins[12:8]);
                end
            end
        end
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per cycle and compares mid-cycle.
    always @(negedge clk) begin
        obs_t got;
        obs_t e;
        if (mon_on) begin
            cycle  = cycle + 1;
            checks = checks + 1;
            got = {sif.pc_en, sif.jump_en, sif.jump, sif.x_dec, sif.y_dec,
                   sif.exec_valid, sif.delay_busy};
            if (exp_q.size() == 0) begin
                $display("FAIL no_expectation cycle %0d: got %b, nothing queued", cycle, got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e)
                    $display("FAIL outputs cycle %0d: got pc=%b je=%b j=%0d xd=%b yd=%b ev=%b db=%b, expected pc=%b je=%b j=%0d xd=%b yd=%b ev=%b db=%b",
                             cycle, got.pc_en, got.jump_en, got.jump, got.x_dec, got.y_dec,
                             got.exec_valid, got.delay_busy, e.pc_en, e.jump_en, e.jump,
                             e.x_dec, e.y_dec, e.exec_valid, e.delay_busy);
                else
                    passed = passed + 1;
            end
        end
    end

    initial begin
        logic [15:0] ins;
        logic [4:0]  dly;
        sif.sm_en = 1'b0; sif.restart = 1'b0; sif.instr = '0; sif.exec_stall = 1'b0;
        sif.x_zero = 1'b0; sif.y_zero = 1'b0; sif.x_ne_y = 1'b0; sif.pin = 1'b0;
        sif.osr_empty = 1'b0;
        mon_on = 1'b1;

        // Reset held: all outputs quiet even with a taken JMP presented.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, mk(JMP, 5'd0, 3'd0, 5'd9), 1'b0, 5'b0);

        // NOP stream, no delay.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, mk(NOP, 5'd0, 3'd0, 5'(i)), 1'b0, 5'b0);

        // Unconditional JMP to 7 with delay 3.
        step(1'b1, 1'b1, 1'b0, mk(JMP, 5'd3, 3'd0, 5'd7), 1'b0, 5'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, mk(NOP, 5'd0, 3'd0, 5'd7), 1'b0, 5'b0);

        // Every condition with all sources low then all high: both outcomes of each.
        for (int cnd = 0; cnd < 8; cnd++)
            for (int v = 0; v < 2; v++)
                step(1'b1, 1'b1, 1'b0, mk(JMP, 5'd0, 3'(cnd), 5'(cnd + 16)), 1'b0, {5{v[0]}});

        // Stall 4 cycles on delay-2 instruction; stall stays high during DELAY.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, mk(NOP, 5'd2, 3'd0, 5'd3), 1'b1, 5'b0);
        step(1'b1, 1'b1, 1'b0, mk(NOP, 5'd2, 3'd0, 5'd3), 1'b0, 5'b0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, mk(NOP, 5'd0, 3'd0, 5'd4), 1'b1, 5'b0);
        step(1'b1, 1'b1, 1'b0, mk(NOP, 5'd0, 3'd0, 5'd4), 1'b0, 5'b0);

        // Delay 5 paused for 3 cycles after 2 DELAY cycles.
        step(1'b1, 1'b1, 1'b0, mk(NOP, 5'd5, 3'd0, 5'd5), 1'b0, 5'b0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, mk(NOP, 5'd0, 3'd0, 5'd6), 1'b0, 5'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, mk(JMP, 5'd0, 3'd0, 5'd6), 1'b0, 5'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, mk(NOP, 5'd0, 3'd0, 5'd6), 1'b0, 5'b0);

        // Restart mid-DELAY, then restart over a taken x-decrementing JMP.
        step(1'b1, 1'b1, 1'b0, mk(JMP, 5'd4, 3'd0, 5'd10), 1'b0, 5'b0);
        step(1'b1, 1'b1, 1'b0, mk(NOP, 5'd0, 3'd0, 5'd11), 1'b0, 5'b0);
        step(1'b1, 1'b1, 1'b1, mk(NOP, 5'd0, 3'd0, 5'd11), 1'b1, 5'b0);
        step(1'b1, 1'b1, 1'b0, mk(NOP, 5'd0, 3'd0, 5'd12), 1'b0, 5'b0);
        step(1'b1, 1'b1, 1'b1, mk(JMP, 5'd2, 3'd2, 5'd13), 1'b0, 5'b0);
        step(1'b1, 1'b1, 1'b0, mk(JMP, 5'd0, 3'd2, 5'd13), 1'b0, 5'b0);

        // Reset asserted mid-DELAY discards the count.
        step(1'b1, 1'b1, 1'b0, mk(NOP, 5'd6, 3'd0, 5'd14), 1'b0, 5'b0);
        step(1'b1, 1'b1, 1'b0, mk(NOP, 5'd0, 3'd0, 5'd14), 1'b0, 5'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, mk(NOP, 5'd0, 3'd0, 5'd14), 1'b0, 5'b0);
        step(1'b1, 1'b1, 1'b0, mk(NOP, 5'd0, 3'd0, 5'd15), 1'b0, 5'b0);

        // Maximum delay: 32 cycles, no wrap.
        step(1'b1, 1'b1, 1'b0, mk(NOP, 5'd31, 3'd0, 5'd1), 1'b0, 5'b0);
        for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 1'b0, mk(NOP, 5'd0, 3'd0, 5'd2), 1'b0, 5'b0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            dly = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 2));
            ins = {($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7)),
                   dly, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
            step(($urandom_range(0, 599) != 0), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 39) == 0), ins, ($urandom_range(0, 4) == 0),
                 5'($urandom_range(0, 31)));
        end

        @(negedge clk);
        #1;
        mon_on = 1'b0;
        checks = checks + 1;
        if (exp_q.size() != 0)
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        else
            passed = passed + 1;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
